ldpc_pin_bridge: RTL and testbench

// - Pad-side front end for the LDPC encoder/decoder core. Sits between the user GPIO pins
//   (mode, serial data, 16-bit select/command bus, serial output) and the codec's parallel ports.
// - Synchronises the asynchronous pad inputs and deserialises message/codeword bits into a

---
 rtl/ldpc_pin_pkg.sv | 25 ++
 rtl/ldpc_pin_sync.sv | 86 ++++++++
 rtl/ldpc_pin_bridge.sv | 159 +++++++++++++++
 tb/tb_ldpc_pin_bridge.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_pin_pkg.sv
// Shared types for the LDPC pad bridge.
// - cmd_t   : pad command field sel[14:13]
// - state_t : bridge FSM states
// - ERR_*   : bit positions in the sticky error vector
package ldpc_pin_pkg;

    typedef enum logic [1:0] {
        CMD_SHIFT_IN  = 2'b00,
        CMD_COMMIT    = 2'b01,
        CMD_SHIFT_OUT = 2'b10,
        CMD_ABORT     = 2'b11
    } cmd_t;

    typedef enum logic [1:0] {
        ST_FILL  = 2'b00,
        ST_OFFER = 2'b01,
        ST_WAIT  = 2'b10,
        ST_DRAIN = 2'b11
    } state_t;

    localparam int unsigned ERR_OVF   = 0;
    localparam int unsigned ERR_EARLY = 1;
    localparam int unsigned ERR_UNDF  = 2;

endpackage

// File: rtl/ldpc_pin_sync.sv
// Pad-input synchroniser with rising-edge detect on the command strobe.
// Optional feature macro: LDPC_PIN_DEGLITCH_EN (strobe must hold a new level for three
// consecutive synchronised cycles before it is recognised).
// Ports:
// - clk_i, rst_i        : clock, synchronous active-high reset
// - strobe_i            : raw pad strobe
// - cmd_i, data_i, mode_i : raw pad command, serial bit, mode
// - strobe_pulse_o      : one-cycle pulse on a recognised rising strobe edge
// - cmd_o, data_o, mode_o : synchronised values, aligned with strobe_pulse_o
module ldpc_pin_sync #(
    parameter int unsigned SYNC_STAGES = 2  // must be at least 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       strobe_i,
    input  logic [1:0] cmd_i,
    input  logic       data_i,
    input  logic       mode_i,
    output logic       strobe_pulse_o,
    output logic [1:0] cmd_o,
    output logic       data_o,
    output logic       mode_o
);

    // All pad bits share one chain so command and data stay aligned with the strobe.
    logic [SYNC_STAGES-1:0][4:0] sync_q;
    logic [4:0]                  sync_last;
    logic                        strobe_s;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= {strobe_i, cmd_i, data_i, mode_i};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_last = sync_q[SYNC_STAGES-1];
    assign strobe_s  = sync_last[4];
    assign cmd_o     = sync_last[3:2];
    assign data_o    = sync_last[1];
    assign mode_o    = sync_last[0];

`ifdef LDPC_PIN_DEGLITCH_EN
    // level_q is the filtered strobe; it only flips after three equal samples in a row.
    logic [1:0] hist_q;
    logic       level_q;
    logic       hi3;
    logic       lo3;

    assign hi3 = strobe_s & hist_q[0] & hist_q[1];
    assign lo3 = ~(strobe_s | hist_q[0] | hist_q[1]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hist_q  <= '0;
            level_q <= 1'b0;
        end else begin
            hist_q <= {hist_q[0], strobe_s};
            if (hi3) begin
                level_q <= 1'b1;
            end else if (lo3) begin
                level_q <= 1'b0;
            end
        end
    end

    assign strobe_pulse_o = hi3 & ~level_q;
`else
    logic prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= strobe_s;
        end
    end

    assign strobe_pulse_o = strobe_s & ~prev_q;
`endif

endmodule

// File: rtl/ldpc_pin_bridge.sv
// Pad-side front end for the LDPC codec: deserialises pad bits into a frame, offers it to the
// codec over valid/ready, accepts the result and serialises it back out on pin_data_o.
// Optional feature macro: LDPC_PIN_DEGLITCH_EN (passed through to ldpc_pin_sync).
// Ports:
// - wb_clk_i, wb_rst_i       : clock, synchronous active-high reset
// - pin_mode_i, pin_data_i   : pad mode (1 = encode) and serial input bit
// - pin_sel_i                : pad [15] strobe, [14:13] command, [12:0] unused
// - pin_data_o               : serial output bit (MSB of result buffer while draining)
// - in_data_o/in_mode_o/in_valid_o/in_ready_i : frame handshake to the codec
// - out_data_i/out_valid_i/out_ready_o        : result handshake from the codec
// - err_o                    : sticky [0] overflow, [1] early commit, [2] underflow
module ldpc_pin_bridge
    import ldpc_pin_pkg::*;
#(
    parameter int unsigned IN_W        = 64,
    parameter int unsigned OUT_W       = 64,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             pin_mode_i,
    input  logic             pin_data_i,
    input  logic [15:0]      pin_sel_i,
    output logic             pin_data_o,
    output logic [IN_W-1:0]  in_data_o,
    output logic             in_mode_o,
    output logic             in_valid_o,
    input  logic             in_ready_i,
    input  logic [OUT_W-1:0] out_data_i,
    input  logic             out_valid_i,
    output logic             out_ready_o,
    output logic [2:0]       err_o
);

    localparam int unsigned FCNT_W = $clog2(IN_W + 1);
    localparam int unsigned DCNT_W = $clog2(OUT_W + 1);
    localparam logic [FCNT_W-1:0] FCNT_FULL = FCNT_W'(IN_W);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(OUT_W - 1);

    logic        strobe_pulse;
    logic [1:0]  cmd_raw;
    cmd_t        cmd;
    logic        sdata;
    logic        smode;
    logic        unused_sel;

    state_t             state_q;
    logic [FCNT_W-1:0]  fcnt_q;
    logic [DCNT_W-1:0]  dcnt_q;
    logic [IN_W-1:0]    ibuf_q;
    logic [OUT_W-1:0]   obuf_q;
    logic               mode_q;
    logic [2:0]         err_q;

    assign unused_sel = ^pin_sel_i[12:0];

    ldpc_pin_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i          (wb_clk_i),
        .rst_i          (wb_rst_i),
        .strobe_i       (pin_sel_i[15]),
        .cmd_i          (pin_sel_i[14:13]),
        .data_i         (pin_data_i),
        .mode_i         (pin_mode_i),
        .strobe_pulse_o (strobe_pulse),
        .cmd_o          (cmd_raw),
        .data_o         (sdata),
        .mode_o         (smode)
    );

    assign cmd = cmd_t'(cmd_raw);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_FILL;
            fcnt_q  <= '0;
            dcnt_q  <= '0;
            ibuf_q  <= '0;
            obuf_q  <= '0;
            mode_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            unique case (state_q)
                ST_FILL: begin
                    if (strobe_pulse) begin
                        unique case (cmd)
                            CMD_SHIFT_IN: begin
                                if (fcnt_q == FCNT_FULL) begin
                                    err_q[ERR_OVF] <= 1'b1;
                                end else begin
                                    ibuf_q <= {ibuf_q[IN_W-2:0], sdata};
                                    fcnt_q <= fcnt_q + 1'b1;
                                end
                            end
                            CMD_COMMIT: begin
                                if (fcnt_q == FCNT_FULL) begin
                                    mode_q  <= smode;
                                    state_q <= ST_OFFER;
                                end else begin
                                    err_q[ERR_EARLY] <= 1'b1;
                                end
                            end
                            CMD_SHIFT_OUT: err_q[ERR_UNDF] <= 1'b1;
                            CMD_ABORT: begin
                                fcnt_q <= '0;
                                ibuf_q <= '0;
                                obuf_q <= '0;
                            end
                        endcase
                    end
                end
                // Valid is never withdrawn once raised, so the pad is ignored here.
                ST_OFFER: begin
                    if (in_ready_i) begin
                        state_q <= ST_WAIT;
                    end
                end
                // An abort in the same cycle as a result consumes and drops that result.
                ST_WAIT: begin
                    if (strobe_pulse && cmd == CMD_ABORT) begin
                        fcnt_q  <= '0;
                        ibuf_q  <= '0;
                        obuf_q  <= '0;
                        state_q <= ST_FILL;
                    end else if (out_valid_i) begin
                        obuf_q  <= out_data_i;
                        dcnt_q  <= '0;
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (strobe_pulse && cmd == CMD_ABORT) begin
                        fcnt_q  <= '0;
                        ibuf_q  <= '0;
                        obuf_q  <= '0;
                        state_q <= ST_FILL;
                    end else if (strobe_pulse && cmd == CMD_SHIFT_OUT) begin
                        obuf_q <= obuf_q << 1;
                        dcnt_q <= dcnt_q + 1'b1;
                        if (dcnt_q == DCNT_LAST) begin
                            fcnt_q  <= '0;
                            ibuf_q  <= '0;
                            state_q <= ST_FILL;
                        end
                    end
                end
            endcase
        end
    end

    assign in_data_o   = ibuf_q;
    assign in_mode_o   = mode_q;
    assign in_valid_o  = (state_q == ST_OFFER);
    assign out_ready_o = (state_q == ST_WAIT);
    assign pin_data_o  = (state_q == ST_DRAIN) & obuf_q[OUT_W-1];
    assign err_o       = err_q;

endmodule

// File: tb/tb_ldpc_pin_bridge.sv
module tb_ldpc_pin_bridge;
    import ldpc_pin_pkg::*;

    logic        wb_clk;
    logic        wb_rst;
    logic        pin_mode;
    logic        pin_data;
    logic [15:0] pin_sel;
    logic        pin_data_out;
    logic [63:0] in_data;
    logic        in_mode;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] frame;
        logic        mode;
        logic [63:0] result;
    } vec_t;

    vec_t vecs[3];

    // Scoreboards: expected frames and expected serial output bits.
    logic [63:0] frame_q[$];
    logic        bit_q[$];

    ldpc_pin_bridge dut (
        .wb_clk_i    (wb_clk),
        .wb_rst_i    (wb_rst),
        .pin_mode_i  (pin_mode),
        .pin_data_i  (pin_data),
        .pin_sel_i   (pin_sel),
        .pin_data_o  (pin_data_out),
        .in_data_o   (in_data),
        .in_mode_o   (in_mode),
        .in_valid_o  (in_valid),
        .in_ready_i  (in_ready),
        .out_data_i  (out_data),
        .out_valid_i (out_valid),
        .out_ready_o (out_ready),
        .err_o       (err)
    );

    initial wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge wb_clk);
        #1;
    endtask

    task automatic pad_cmd(input logic [1:0] c, input logic b);
        pin_sel  = {1'b1, c, 13'h0};
        pin_data = b;
        tick(7);
        pin_sel[15] = 1'b0;
        tick(7);
    endtask

    task automatic shift_frame(input logic [63:0] f, input int nbits);
        for (int i = 63; i >= 64 - nbits; i--) begin
            pad_cmd(CMD_SHIFT_IN, f[i]);
        end
    endtask

    task automatic wait_offer();
        logic [63:0] exp;
        int n;
        n = 0;
        while (!in_valid && n < 30) begin
            tick(1);
            n++;
        end
        check("offer_valid", in_valid, 1);
        if (frame_q.size() > 0) begin
            exp = frame_q.pop_front();
            check("offer_data", in_data, exp);
        end
    endtask

    task automatic accept_frame();
        in_ready = 1'b1;
        tick(1);
        in_ready = 1'b0;
        check("wait_valid_low", in_valid, 0);
        check("wait_ready_high", out_ready, 1);
    endtask

    task automatic give_result(input logic [63:0] r);
        out_data  = r;
        out_valid = 1'b1;
        for (int i = 63; i >= 0; i--) bit_q.push_back(r[i]);
        tick(1);
        out_valid = 1'b0;
        check("drain_ready_low", out_ready, 0);
    endtask

    task automatic drain_bits(input int n);
        logic b;
        for (int k = 0; k < n; k++) begin
            b = bit_q.pop_front();
            check("drain_bit", pin_data_out, b);
            pad_cmd(CMD_SHIFT_OUT, 1'b0);
        end
    endtask

    initial begin
        logic [63:0] f;
        vecs[0] = '{64'hA5A5_0F0F_1234_5678, 1'b1, 64'h0123_4567_89AB_CDEF};
        vecs[1] = '{64'hFFFF_0000_DEAD_BEEF, 1'b0, 64'h8000_0000_0000_0001};
        vecs[2] = '{64'h0000_0000_0000_0001, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF};

        wb_rst = 1'b1; pin_mode = 1'b0; pin_data = 1'b0; pin_sel = '0;
        in_ready = 1'b0; out_data = '0; out_valid = 1'b0;
        tick(3);
        wb_rst = 1'b0;
        tick(1);
        check("rst_pin_data", pin_data_out, 0);
        check("rst_in_valid", in_valid, 0);
        check("rst_out_ready", out_ready, 0);
        check("rst_in_data", in_data, 0);
        check("rst_in_mode", in_mode, 0);
        check("rst_err", err, 0);

        // Full frames through the bridge.
        for (int v = 0; v < 3; v++) begin
            pin_mode = vecs[v].mode;
            shift_frame(vecs[v].frame, 64);
            check("fill_no_valid", in_valid, 0);
            frame_q.push_back(vecs[v].frame);
            pad_cmd(CMD_COMMIT, 1'b0);
            pin_mode = ~vecs[v].mode;
            wait_offer();
            check("offer_mode", in_mode, vecs[v].mode);
            if (v == 0) begin
                for (int c = 0; c < 10; c++) begin
                    tick(1);
                    check("offer_hold_data", in_data, vecs[v].frame);
                    check("offer_hold_mode", in_mode, vecs[v].mode);
                end
                pad_cmd(CMD_ABORT, 1'b0);
                check("offer_abort_ignored", in_valid, 1);
                check("offer_abort_data", in_data, vecs[v].frame);
            end
            accept_frame();
            give_result(vecs[v].result);
            drain_bits(64);
            check("drain_done_pin", pin_data_out, 0);
            check("drain_done_ready", out_ready, 0);
            check("drain_done_ibuf", in_data, 0);
            check("drain_done_err", err, 0);
        end

        // Overflow: 65 bits, the last one ignored.
        f = 64'h1357_9BDF_2468_ACE0;
        pin_mode = 1'b1;
        shift_frame(f, 64);
        pad_cmd(CMD_SHIFT_IN, 1'b1);
        check("ovf_err", err, 3'b001);
        frame_q.push_back(f);
        pad_cmd(CMD_COMMIT, 1'b0);
        wait_offer();
        accept_frame();
        pad_cmd(CMD_ABORT, 1'b0);
        check("wait_abort_ready", out_ready, 0);
        check("wait_abort_ibuf", in_data, 0);
        out_valid = 1'b1;
        tick(2);
        check("late_result_refused", out_ready, 0);
        out_valid = 1'b0;

        // Early commit, then underflow in FILL.
        shift_frame(64'hF800_0000_0000_0000, 5);
        pad_cmd(CMD_COMMIT, 1'b0);
        check("early_no_valid", in_valid, 0);
        check("early_err", err, 3'b011);
        pad_cmd(CMD_SHIFT_OUT, 1'b0);
        check("undf_err", err, 3'b111);
        pad_cmd(CMD_ABORT, 1'b0);
        check("fill_abort_err", err, 3'b111);

        // Abort during DRAIN at dcnt=10.
        f = 64'h0F0F_F0F0_5555_AAAA;
        shift_frame(f, 64);
        frame_q.push_back(f);
        pad_cmd(CMD_COMMIT, 1'b0);
        wait_offer();
        accept_frame();
        give_result(64'hFFFF_FFFF_FFFF_FFFF);
        drain_bits(10);
        check("dcnt10_pin", pin_data_out, 1);
        pad_cmd(CMD_ABORT, 1'b0);
        bit_q.delete();
        check("drain_abort_pin", pin_data_out, 0);
        check("drain_abort_ibuf", in_data, 0);
        check("drain_abort_ready", out_ready, 0);
        check("drain_abort_err", err, 3'b111);

        // Reset mid-DRAIN.
        pin_mode = 1'b1;
        shift_frame(f, 64);
        frame_q.push_back(f);
        pad_cmd(CMD_COMMIT, 1'b0);
        wait_offer();
        accept_frame();
        give_result(64'hFFFF_FFFF_FFFF_FFFF);
        drain_bits(3);
        bit_q.delete();
        wb_rst = 1'b1;
        tick(1);
        wb_rst = 1'b0;
        check("mrst_pin", pin_data_out, 0);
        check("mrst_valid", in_valid, 0);
        check("mrst_ready", out_ready, 0);
        check("mrst_data", in_data, 0);
        check("mrst_mode", in_mode, 0);
        check("mrst_err", err, 0);
        pad_cmd(CMD_COMMIT, 1'b0);
        check("mrst_fill_commit", in_valid, 0);
        check("mrst_fill_err", err, 3'b010);

        // One-cycle strobe glitch as the 64th SHIFT_IN.
        f = 64'h0F1E_2D3C_4B5A_6979;
        pin_mode = 1'b0;
        shift_frame(f, 63);
        pin_sel  = {1'b0, CMD_SHIFT_IN, 13'h0};
        pin_data = f[0];
        tick(3);
        pin_sel[15] = 1'b1;
        tick(1);
        pin_sel[15] = 1'b0;
        tick(12);
        pad_cmd(CMD_COMMIT, 1'b0);
`ifdef LDPC_PIN_DEGLITCH_EN
        check("glitch_no_valid", in_valid, 0);
        check("glitch_err", err, 3'b010);
`else
        check("glitch_valid", in_valid, 1);
        check("glitch_data", in_data, f);
        check("glitch_mode", in_mode, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
